// File: rtl/pipelined_decode_ctrl.sv
// ID/EX control stage: registered decode, valid/ready, load-use interlock.
// Optional: DECODE_ILLEGAL_TRAP_EN turns undefined opcodes into trapped NOPs.
module pipelined_decode_ctrl #(
  parameter int OPCODE_W   = 7,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic [3:0]            alu_op,
  output logic [1:0]            alu_src,
  output logic                  jump,
  output logic                  beq,
  output logic                  bne,
  output logic                  data_read_en,
  output logic                  data_write_en,
  output logic                  mem_to_reg,
  output logic                  reg_write_en,
  output logic [REG_ADDR_W-1:0] rd_q,
  output logic [REG_ADDR_W-1:0] rs1_q,
  output logic [REG_ADDR_W-1:0] rs2_q,
  output logic [CNT_W-1:0]      stall_count,
  output logic                  illegal_op
);

  typedef struct packed {
    logic [3:0] alu_op;
    logic [1:0] alu_src;
    logic       jump;
    logic       beq;
    logic       bne;
    logic       rd_en;
    logic       wr_en;
    logic       m2r;
    logic       rwe;
  } ctrl_t;

  ctrl_t                 dec_d, ctrl_q;
  logic                  use1, use2;
  logic                  valid_q;
  logic [REG_ADDR_W-1:0] rd_r, rs1_r, rs2_r;
  logic [CNT_W-1:0]      stall_q;
  logic                  advance, hazard;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic                  ill_d, ill_q;
`endif

  always_comb begin
    dec_d = '0;
    use1  = 1'b0;
    use2  = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    ill_d = 1'b0;
`endif
    case (opcode)
      OPCODE_W'(0): begin
        dec_d.alu_src = 2'b01;
        dec_d.m2r     = 1'b1;
        dec_d.rwe     = 1'b1;
        dec_d.rd_en   = 1'b1;
        use1          = 1'b1;
      end
      OPCODE_W'(1): begin
        dec_d.alu_src = 2'b01;
        dec_d.wr_en   = 1'b1;
        use1          = 1'b1;
        use2          = 1'b1;
      end
      OPCODE_W'(2), OPCODE_W'(3), OPCODE_W'(5),
      OPCODE_W'(6), OPCODE_W'(7), OPCODE_W'(8),
      OPCODE_W'(9): begin
        dec_d.alu_op = 4'(opcode - OPCODE_W'(2));
        dec_d.rwe    = 1'b1;
        use1         = 1'b1;
        use2         = 1'b1;
      end
      OPCODE_W'(4): begin
        dec_d.alu_op = 4'b0010;
        dec_d.rwe    = 1'b1;
        use1         = 1'b1;
      end
      OPCODE_W'(11): begin
        dec_d.alu_op = 4'b0001;
        dec_d.beq    = 1'b1;
        use1         = 1'b1;
        use2         = 1'b1;
      end
      OPCODE_W'(12): begin
        dec_d.alu_op = 4'b0001;
        dec_d.bne    = 1'b1;
        use1         = 1'b1;
        use2         = 1'b1;
      end
      OPCODE_W'(13): dec_d.jump = 1'b1;
      OPCODE_W'(14): begin
        dec_d.alu_op  = 4'b1000;
        dec_d.alu_src = 2'b10;
        dec_d.rwe     = 1'b1;
      end
      OPCODE_W'(15): begin
        dec_d.alu_op  = 4'b1001;
        dec_d.alu_src = 2'b10;
        dec_d.rwe     = 1'b1;
      end
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        ill_d = 1'b1;
`else
        dec_d.rwe = 1'b1;
`endif
      end
    endcase
  end

  assign advance  = ~valid_q | out_ready;
  assign hazard   = valid_q & ctrl_q.rd_en & in_valid &
                    ((use1 & (rs1 == rd_r)) |
                     (use2 & (rs2 == rd_r)));
  assign in_ready = advance & ~hazard & ~reset;

  // Control bits are cleared with valid so an empty slot never writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd_r    <= '0;
      rs1_r   <= '0;
      rs2_r   <= '0;
      stall_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (advance & hazard) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      if (stall_q != '1) stall_q <= stall_q + 1'b1;
    end else if (advance & in_valid) begin
      valid_q <= 1'b1;
      ctrl_q  <= dec_d;
      rd_r    <= rd;
      rs1_r   <= rs1;
      rs2_r   <= rs2;
    end else if (advance) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset | flush) ill_q <= 1'b0;
    else ill_q <= advance & ~hazard & in_valid & ill_d;
  end
  assign illegal_op = ill_q;
`else
  assign illegal_op = 1'b0;
`endif

  assign out_valid     = valid_q;
  assign alu_op        = ctrl_q.alu_op;
  assign alu_src       = ctrl_q.alu_src;
  assign jump          = ctrl_q.jump;
  assign beq           = ctrl_q.beq;
  assign bne           = ctrl_q.bne;
  assign data_read_en  = ctrl_q.rd_en;
  assign data_write_en = ctrl_q.wr_en;
  assign mem_to_reg    = ctrl_q.m2r;
  assign reg_write_en  = ctrl_q.rwe;
  assign rd_q          = rd_r;
  assign rs1_q         = rs1_r;
  assign rs2_q         = rs2_r;
  assign stall_count   = stall_q;

endmodule
